// File: rtl/exp_golomb_stream_decoder_pkg.sv
// Shared state encoding, width helpers and the ue->se mapping for the Exp-Golomb stream decoder.
package exp_golomb_pkg;

   typedef enum logic [1:0] {
      S_ZEROS = 2'd0,
      S_INFO  = 2'd1,
      S_OUT   = 2'd2,
      S_ERR   = 2'd3
   } eg_state_e;

   // Leading-zero counter must reach MAX_LZ+1 to flag the malformed case.
   function automatic int eg_lz_w(input int max_lz);
      return $clog2(max_lz + 2);
   endfunction

   function automatic int eg_fill_w(input int in_w);
      return $clog2(2 * in_w + 1);
   endfunction

   // Code number k -> signed value: odd k -> +(k+1)/2, even k -> -(k/2).
   function automatic logic signed [63:0] eg_ue_to_se(input logic [63:0] k);
      logic [63:0] half;
      half = (k >> 1) + {63'd0, k[0]};
      return k[0] ? $signed(half) : -$signed(half);
   endfunction

endpackage

// File: rtl/exp_golomb_stream_decoder_bit_buffer.sv
// Two-word MSB-first bit buffer: accepts whole words while at most half full, yields one bit per pop.
module eg_bit_buffer
   import exp_golomb_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] push_data_i,
   input  logic            push_i,
   input  logic            pop_i,
   output logic            ready_o,
   output logic            head_o,
   output logic            avail_o
);

   localparam int BUF_W  = 2 * IN_W;
   localparam int FILL_W = eg_fill_w(IN_W);

   logic [BUF_W-1:0]  bits_q;
   logic [BUF_W-1:0]  bits_d;
   logic [BUF_W-1:0]  shifted;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_d;
   logic [FILL_W-1:0] rem;
   logic              do_push;
   logic              do_pop;

   assign ready_o = rst_n && (fill_q <= FILL_W'(IN_W));
   assign avail_o = (fill_q != '0);
   assign head_o  = bits_q[BUF_W-1];
   assign do_push = push_i && ready_o;
   assign do_pop  = pop_i && avail_o;

   // Valid bits sit left-justified; everything below fill stays zero so a new word can be OR-ed in.
   always_comb begin
      shifted = do_pop ? {bits_q[BUF_W-2:0], 1'b0} : bits_q;
      rem     = fill_q - FILL_W'(do_pop);
      bits_d  = shifted;
      fill_d  = rem;
      if (do_push) begin
         bits_d = shifted | ({push_data_i, {IN_W{1'b0}}} >> rem);
         fill_d = rem + FILL_W'(IN_W);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q <= '0;
         fill_q <= '0;
      end else begin
         bits_q <= bits_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/exp_golomb_stream_decoder.sv
// Bit-serial Exp-Golomb ue(v)/se(v) decoder with ready/valid ports and malformed-code flagging.
// Define EXP_GOLOMB_SE_EN to add the se_mode port and signed se(v) mapping.
module exp_golomb_stream_decoder
   import exp_golomb_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 17,
   parameter int MAX_LZ = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  axiid,
   input  logic             axiiv,
   output logic             axiir,
`ifdef EXP_GOLOMB_SE_EN
   input  logic             se_mode,
`endif
   output logic [OUT_W-1:0] axiod,
   output logic             axiov,
   input  logic             axior,
   output logic             axioerr
);

   localparam int LZ_W = eg_lz_w(MAX_LZ);
   localparam logic [MAX_LZ:0] UE_ONE = {{MAX_LZ{1'b0}}, 1'b1};

   eg_state_e          state_q;
   logic [LZ_W-1:0]    lz_q;
   logic [LZ_W-1:0]    cnt_q;
   logic [MAX_LZ-1:0]  info_q;
   logic [MAX_LZ-1:0]  info_d;
   logic [MAX_LZ:0]    ue_d;
   logic [OUT_W-1:0]   val_d;
   logic [OUT_W-1:0]   res_q;
   logic [OUT_W-1:0]   axiod_q;
   logic               axiov_q;
   logic               axioerr_q;
   logic               bit_head;
   logic               bit_avail;
   logic               pop;
`ifdef EXP_GOLOMB_SE_EN
   logic               se_q;
`endif

   assign pop = bit_avail && ((state_q == S_ZEROS) || (state_q == S_INFO));

   eg_bit_buffer #(
      .IN_W(IN_W)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_data_i(axiid),
      .push_i     (axiiv),
      .pop_i      (pop),
      .ready_o    (axiir),
      .head_o     (bit_head),
      .avail_o    (bit_avail)
   );

   // ue arithmetic is exact in MAX_LZ+1 bits: max is 2^(MAX_LZ+1)-2.
   assign info_d = {info_q[MAX_LZ-2:0], bit_head};
   assign ue_d   = (UE_ONE << lz_q) - UE_ONE + {1'b0, info_d};

`ifdef EXP_GOLOMB_SE_EN
   assign val_d = se_q ? OUT_W'(eg_ue_to_se(64'(ue_d))) : OUT_W'(ue_d);
`else
   assign val_d = OUT_W'(ue_d);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_ZEROS;
         lz_q      <= '0;
         cnt_q     <= '0;
         info_q    <= '0;
         res_q     <= '0;
         axiod_q   <= '0;
         axiov_q   <= 1'b0;
         axioerr_q <= 1'b0;
`ifdef EXP_GOLOMB_SE_EN
         se_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_ZEROS: begin
               if (bit_avail) begin
`ifdef EXP_GOLOMB_SE_EN
                  if (lz_q == '0) se_q <= se_mode;
`endif
                  if (!bit_head) begin
                     lz_q <= lz_q + LZ_W'(1);
                     if (lz_q == LZ_W'(MAX_LZ)) state_q <= S_ERR;
                  end else if (lz_q == '0) begin
                     res_q   <= '0;
                     state_q <= S_OUT;
                  end else begin
                     info_q  <= '0;
                     cnt_q   <= lz_q;
                     state_q <= S_INFO;
                  end
               end
            end
            S_INFO: begin
               if (bit_avail) begin
                  info_q <= info_d;
                  cnt_q  <= cnt_q - LZ_W'(1);
                  if (cnt_q == LZ_W'(1)) begin
                     res_q   <= val_d;
                     state_q <= S_OUT;
                  end
               end
            end
            // Output register stage: beat appears one cycle after the last bit, then waits for axior.
            S_OUT: begin
               if (!axiov_q) begin
                  axiov_q <= 1'b1;
                  axiod_q <= res_q;
               end else if (axior) begin
                  axiov_q <= 1'b0;
                  lz_q    <= '0;
                  state_q <= S_ZEROS;
               end
            end
            S_ERR: begin
               if (!axiov_q) begin
                  axiov_q   <= 1'b1;
                  axioerr_q <= 1'b1;
                  axiod_q   <= '0;
               end else if (axior) begin
                  axiov_q   <= 1'b0;
                  axioerr_q <= 1'b0;
                  lz_q      <= '0;
                  state_q   <= S_ZEROS;
               end
            end
            default: state_q <= S_ZEROS;
         endcase
      end
   end

   assign axiod   = axiod_q;
   assign axiov   = axiov_q;
   assign axioerr = axioerr_q;

endmodule
